audio_conditioner: RTL and testbench

- Downstream stage of the console top level. Consumes the raw per-clock AUDIO_L/AUDIO_R sums: unsigned 16-bit, TIA LUT plus POKEY plus YM, which can carry large DC offsets.
- Boxcar-decimates each channel to a fixed sample rate, removes DC with a first-order high-pass IIR and saturates to signed 16-bit.
- Presents one strobed stereo sample to the platform audio path.

---
 rtl/audio_conditioner.sv | 152 +++++++++++++++
 tb/tb_audio_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_conditioner.sv
`default_nettype none
// =============================================================================
// Module  : audio_conditioner
// Purpose : Boxcar decimation, DC-blocking high-pass and s16 saturation of the
//           raw stereo sums. Define AUDIO_LPF_EN to add a one-pole smoother.
// Revision: 1.0
// =============================================================================

module audio_conditioner #(
    parameter int DIV_LOG2  = 9,
    parameter int HPF_SHIFT = 8,
    parameter int LPF_SHIFT = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] audio_l_in,
    input  logic [15:0] audio_r_in,
    input  logic        mute,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        sample_valid
);

    localparam int ACC_W = 16 + DIV_LOG2;
    localparam int Y_W   = 26;

    function automatic logic [15:0] sat16(input logic signed [Y_W-1:0] v);
        logic signed [Y_W-1:0] s;
        s = v >>> 8;
        if (s > 26'sd32767)
            return 16'h7fff;
        else if (s < -26'sd32768)
            return 16'h8000;
        else
            return s[15:0];
    endfunction

    logic [DIV_LOG2-1:0] cnt_q;
    logic                wrap_w;
    logic                avg_vld_q;
    logic                hpf_vld_q;
    logic                primed_q;
    logic                out_vld_w;
    logic                sample_valid_q;

    assign wrap_w = &cnt_q;

`ifdef AUDIO_LPF_EN
    logic lpf_vld_q;
    logic prime_w;

    assign prime_w   = avg_vld_q && !primed_q && !mute;
    assign out_vld_w = lpf_vld_q;

    always_ff @(posedge clk_sys) begin
        if (reset)
            lpf_vld_q <= 1'b0;
        else
            lpf_vld_q <= hpf_vld_q;
    end
`else
    assign out_vld_w = hpf_vld_q;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q          <= '0;
            avg_vld_q      <= 1'b0;
            hpf_vld_q      <= 1'b0;
            primed_q       <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_q + 1'b1;
            avg_vld_q      <= wrap_w;
            hpf_vld_q      <= avg_vld_q;
            sample_valid_q <= out_vld_w;
            if (mute)
                primed_q <= 1'b0;
            else if (avg_vld_q)
                primed_q <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic        [15:0]      in_w;
        logic        [ACC_W-1:0] acc_q;
        logic        [ACC_W-1:0] sum_w;
        logic        [15:0]      avg_q;
        logic signed [16:0]      x_w;
        logic signed [16:0]      xprev_q;
        logic signed [17:0]      diff_w;
        logic signed [Y_W-1:0]   step_w;
        logic signed [Y_W-1:0]   y_q;
        logic signed [Y_W-1:0]   y_d;
        logic signed [Y_W-1:0]   src_w;
        logic        [15:0]      out_q;

        assign in_w   = (ch == 0) ? audio_l_in : audio_r_in;
        // The wrap-cycle input is folded into the average, so acc never holds it.
        assign sum_w  = acc_q + {{DIV_LOG2{1'b0}}, in_w};
        assign x_w    = $signed({1'b0, avg_q});
        assign diff_w = $signed({x_w[16], x_w}) - $signed({xprev_q[16], xprev_q});
        assign step_w = $signed({diff_w, 8'd0});
        assign y_d    = y_q + step_w - (y_q >>> HPF_SHIFT);

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                acc_q   <= '0;
                avg_q   <= '0;
                xprev_q <= '0;
                y_q     <= '0;
                out_q   <= '0;
            end else begin
                acc_q <= wrap_w ? '0 : sum_w;
                if (wrap_w)
                    avg_q <= sum_w[ACC_W-1:DIV_LOG2];
                if (mute)
                    y_q <= '0;
                else if (avg_vld_q) begin
                    xprev_q <= x_w;
                    y_q     <= primed_q ? y_d : '0;
                end
                if (out_vld_w)
                    out_q <= mute ? 16'h0000 : sat16(src_w);
            end
        end

`ifdef AUDIO_LPF_EN
        logic signed [Y_W-1:0] z_q;
        logic signed [Y_W-1:0] z_d;

        assign z_d   = z_q + ((y_q - z_q) >>> LPF_SHIFT);
        assign src_w = z_q;

        always_ff @(posedge clk_sys) begin
            if (reset || mute || prime_w)
                z_q <= '0;
            else if (hpf_vld_q)
                z_q <= z_d;
        end
`else
        assign src_w = y_q;
`endif
    end

    assign audio_l      = g_ch[0].out_q;
    assign audio_r      = g_ch[1].out_q;
    assign sample_valid = sample_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_conditioner.sv
`default_nettype none
// =============================================================================
// Module  : tb_audio_conditioner
// Purpose : Scoreboard bench for audio_conditioner (LPF off, 512-cycle window).
// Revision: 1.0
// =============================================================================

module tb_audio_conditioner;

    localparam int WIN = 512;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        mute    = 1'b0;
    logic [15:0] l_in    = 16'h0000;
    logic [15:0] r_in    = 16'h0000;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int     m_cnt = 0;
    longint m_acc [2];
    longint m_avg [2];
    longint m_xp  [2];
    longint m_y   [2];
    bit     m_p1 = 0, m_p2 = 0, m_primed = 0, m_sv = 0;
    longint exp_l_q[$];
    longint exp_r_q[$];

    audio_conditioner #(.DIV_LOG2(9), .HPF_SHIFT(8), .LPF_SHIFT(2)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .audio_l_in   (l_in),
        .audio_r_in   (r_in),
        .mute         (mute),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .sample_valid (sample_valid)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_edge(input logic [15:0] l, input logic [15:0] r,
                              input logic m, input logic rst);
        longint in_v [2];
        in_v[0] = l;
        in_v[1] = r;
        if (rst) begin
            m_cnt = 0; m_p1 = 0; m_p2 = 0; m_primed = 0; m_sv = 0;
            for (int c = 0; c < 2; c++) begin
                m_acc[c] = 0; m_avg[c] = 0; m_xp[c] = 0; m_y[c] = 0;
            end
            return;
        end
        m_sv = m_p2;
        if (m_p2) begin
            exp_l_q.push_back(m ? 0 : sat(m_y[0] >>> 8));
            exp_r_q.push_back(m ? 0 : sat(m_y[1] >>> 8));
        end
        if (m) begin
            m_primed = 0;
            m_y[0] = 0;
            m_y[1] = 0;
        end else if (m_p1) begin
            for (int c = 0; c < 2; c++) begin
                if (!m_primed)
                    m_y[c] = 0;
                else
                    m_y[c] = m_y[c] + (m_avg[c] - m_xp[c]) * 256 - (m_y[c] >>> 8);
                m_xp[c] = m_avg[c];
            end
            m_primed = 1;
        end
        m_p2 = m_p1;
        if (m_cnt == WIN - 1) begin
            for (int c = 0; c < 2; c++) begin
                m_avg[c] = (m_acc[c] + in_v[c]) >> 9;
                m_acc[c] = 0;
            end
            m_p1 = 1;
        end else begin
            for (int c = 0; c < 2; c++) m_acc[c] += in_v[c];
            m_p1 = 0;
        end
        m_cnt = (m_cnt + 1) % WIN;
    endtask

    task automatic step(input logic [15:0] l, input logic [15:0] r,
                        input logic m, input logic rst, output bit sv);
        longint el, er;
        l_in  = l;
        r_in  = r;
        mute  = m;
        reset = rst;
        @(posedge clk_sys);
        model_edge(l, r, m, rst);
        #1;
        check_val("strobe", sample_valid, m_sv);
        if (sample_valid) begin
            check_val("sb_depth", exp_l_q.size(), 1);
            if (exp_l_q.size() > 0) begin
                el = exp_l_q.pop_front();
                er = exp_r_q.pop_front();
                check_val("sb_l", $signed(audio_l), el);
                check_val("sb_r", $signed(audio_r), er);
            end
        end else begin
            exp_l_q.delete();
            exp_r_q.delete();
        end
        sv = sample_valid;
    endtask

    task automatic run_to_strobe(input logic [15:0] l, input logic [15:0] r,
                                 input logic m, output int cycles);
        bit sv;
        sv = 0;
        cycles = 0;
        for (int i = 0; i < WIN + 16; i++) begin
            step(l, r, m, 1'b0, sv);
            cycles++;
            if (sv) break;
        end
        if (!sv) check_val("strobe_timeout", sv, 1);
    endtask

    task automatic align(input logic [15:0] l, input logic [15:0] r,
                         input logic m, input int pos);
        bit sv;
        for (int i = 0; i < WIN && m_cnt != pos; i++) step(l, r, m, 1'b0, sv);
    endtask

    task automatic do_reset(input logic [15:0] l, input logic [15:0] r);
        bit sv;
        step(l, r, 1'b0, 1'b1, sv);
    endtask

    initial begin
        int cyc;
        bit sv;

        // Constant input from reset: first strobe at 514, all zero, 512 apart
        do_reset(16'h4000, 16'h4000);
        do_reset(16'h4000, 16'h4000);
        check_val("rst_l", $signed(audio_l), 0);
        check_val("rst_r", $signed(audio_r), 0);
        check_val("rst_sv", sample_valid, 0);
        run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
        check_val("t1_first_lat", cyc, 514);
        check_val("t1_first_l", $signed(audio_l), 0);
        for (int k = 0; k < 3; k++) begin
            run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
            check_val("t1_spacing", cyc, WIN);
            check_val("t1_val", $signed(audio_l), 0);
        end

        // Aligned step on left 0x4000 -> 0x6000
        align(16'h4000, 16'h4000, 1'b0, 0);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t2_prev", $signed(audio_l), 0);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t2_s0_l", $signed(audio_l), 8192);
        check_val("t2_s0_r", $signed(audio_r), 0);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t2_s1_l", $signed(audio_l), 8160);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t2_s2_l", $signed(audio_l), 8128);
        check_val("t2_s2_r", $signed(audio_r), 0);

        // Full-scale steps saturate both ways
        do_reset(16'h0000, 16'h0000);
        run_to_strobe(16'h0000, 16'h0000, 1'b0, cyc);
        check_val("t3_lat", cyc, 514);
        align(16'h0000, 16'h0000, 1'b0, 0);
        run_to_strobe(16'hffff, 16'hffff, 1'b0, cyc);
        run_to_strobe(16'hffff, 16'hffff, 1'b0, cyc);
        check_val("t3_pos_l", $signed(audio_l), 32767);
        check_val("t3_pos_r", $signed(audio_r), 32767);
        do_reset(16'hffff, 16'hffff);
        run_to_strobe(16'hffff, 16'hffff, 1'b0, cyc);
        check_val("t3_reprime", $signed(audio_l), 0);
        align(16'hffff, 16'hffff, 1'b0, 0);
        run_to_strobe(16'h0000, 16'h0000, 1'b0, cyc);
        run_to_strobe(16'h0000, 16'h0000, 1'b0, cyc);
        check_val("t3_neg_l", $signed(audio_l), -32768);
        check_val("t3_neg_r", $signed(audio_r), -32768);

        // Mid-window step: half-window average
        do_reset(16'h4000, 16'h4000);
        run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
        align(16'h4000, 16'h4000, 1'b0, 256);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t4_half", $signed(audio_l), 4096);
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t4_next", $signed(audio_l), 8176);

        // Mute for three windows during the decay, then re-prime
        for (int k = 0; k < 3; k++) begin
            run_to_strobe(16'h6000, 16'h4000, 1'b1, cyc);
            check_val("t5_mute_spacing", cyc, WIN);
            check_val("t5_mute_l", $signed(audio_l), 0);
        end
        run_to_strobe(16'h6000, 16'h4000, 1'b0, cyc);
        check_val("t5_primed", $signed(audio_l), 0);
        align(16'h6000, 16'h4000, 1'b0, 0);
        run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
        check_val("t5_flat", $signed(audio_l), 0);
        run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
        check_val("t5_resume", $signed(audio_l), -8192);

        // One-cycle reset mid-window with a nonzero output
        align(16'h4000, 16'h4000, 1'b0, 100);
        step(16'h4000, 16'h4000, 1'b0, 1'b1, sv);
        check_val("t6_rst_l", $signed(audio_l), 0);
        check_val("t6_rst_r", $signed(audio_r), 0);
        check_val("t6_rst_sv", sample_valid, 0);
        run_to_strobe(16'h4000, 16'h4000, 1'b0, cyc);
        check_val("t6_lat", cyc, 514);
        check_val("t6_val", $signed(audio_l), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
